// File: rtl/bcd_to_bin_accum.sv
// Accumulates MSD-first BCD digits into a saturating binary value with valid/ready output.
// Optional macro BCD2BIN_ECHO_SEG_EN adds echo_seg, a seven-segment echo of the last accepted digit.
module bcd_to_bin_accum #(
    parameter int NUM_DIGITS = 2,
    parameter int BIN_W      = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             digit_valid,
    input  logic [3:0]       digit_in,
    input  logic             digit_last,
    output logic             digit_ready,
    output logic             bin_valid,
    input  logic             bin_ready,
    output logic [BIN_W-1:0] bin_out,
    output logic             overflow,
    output logic             digit_err
`ifdef BCD2BIN_ECHO_SEG_EN
    ,
    output logic [6:0]       echo_seg
`endif
);

    localparam int EXT_W = BIN_W + 4;
    localparam logic [3:0] LAST_CNT = 4'(NUM_DIGITS - 1);

    typedef enum logic {ACCUM, OUT} state_t;

    state_t           state_q;
    logic [BIN_W-1:0] acc_q;
    logic [3:0]       count_q;
    logic             ovf_q;
    logic             err_q;
    logic             digit_ready_q;
    logic             bin_valid_q;
    logic [BIN_W-1:0] bin_out_q;
    logic             overflow_q;
    logic             digit_err_q;

    logic             digit_bad;
    logic [3:0]       digit_eff;
    logic [EXT_W-1:0] acc_ext;
    logic [EXT_W-1:0] prod;
    logic             sat;
    logic [BIN_W-1:0] acc_d;
    logic [3:0]       count_d;
    logic             ovf_d;
    logic             err_d;
    logic             accept;
    logic             closing;

    // Clamp the widened product to the largest representable result.
    function automatic logic [BIN_W-1:0] sat_acc(input logic [EXT_W-1:0] v, input logic over);
        return over ? {BIN_W{1'b1}} : v[BIN_W-1:0];
    endfunction

    always_comb begin
        digit_bad = (digit_in > 4'd9);
        digit_eff = digit_bad ? 4'd0 : digit_in;
        acc_ext   = {4'b0000, acc_q};
        prod      = (acc_ext << 3) + (acc_ext << 1) + {{BIN_W{1'b0}}, digit_eff};
        sat       = (prod > {4'b0000, {BIN_W{1'b1}}});
        acc_d     = sat_acc(prod, sat);
        count_d   = count_q + 4'd1;
        ovf_d     = ovf_q | sat;
        err_d     = err_q | digit_bad;
        accept    = digit_valid && (state_q == ACCUM);
        closing   = digit_last || (count_q == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ACCUM;
            acc_q         <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            err_q         <= 1'b0;
            digit_ready_q <= 1'b1;
            bin_valid_q   <= 1'b0;
            bin_out_q     <= '0;
            overflow_q    <= 1'b0;
            digit_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        ovf_q   <= ovf_d;
                        err_q   <= err_d;
                        if (closing) begin
                            state_q       <= OUT;
                            bin_out_q     <= acc_d;
                            overflow_q    <= ovf_d;
                            digit_err_q   <= err_d;
                            digit_ready_q <= 1'b0;
                            bin_valid_q   <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    // Result held until the consumer takes it; the next number starts clean.
                    if (bin_ready) begin
                        state_q       <= ACCUM;
                        acc_q         <= '0;
                        count_q       <= '0;
                        ovf_q         <= 1'b0;
                        err_q         <= 1'b0;
                        digit_ready_q <= 1'b1;
                        bin_valid_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    assign digit_ready = digit_ready_q;
    assign bin_valid   = bin_valid_q;
    assign bin_out     = bin_out_q;
    assign overflow    = overflow_q;
    assign digit_err   = digit_err_q;

`ifdef BCD2BIN_ECHO_SEG_EN
    logic [6:0] echo_q;

    // Active-low segments, bit0 = a ... bit6 = g; non-decimal codes show a dash.
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] on;
        case (d)
            4'd0:    on = 7'h3F;
            4'd1:    on = 7'h06;
            4'd2:    on = 7'h5B;
            4'd3:    on = 7'h4F;
            4'd4:    on = 7'h66;
            4'd5:    on = 7'h6D;
            4'd6:    on = 7'h7D;
            4'd7:    on = 7'h07;
            4'd8:    on = 7'h7F;
            4'd9:    on = 7'h6F;
            default: on = 7'h40;
        endcase
        return ~on;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            echo_q <= 7'b1000000;
        end else if (accept) begin
            echo_q <= seg_pattern(digit_in);
        end
    end

    assign echo_seg = echo_q;
`endif

endmodule

// File: tb/tb_bcd_to_bin_accum.sv
// Scoreboard bench for bcd_to_bin_accum: a default instance (2 digits) and a 3-digit instance.
module tb_bcd_to_bin_accum;

    typedef struct packed {
        logic [6:0] bin;
        logic       ovf;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       dv0 = 1'b0, dl0 = 1'b0, br0 = 1'b0;
    logic [3:0] din0 = 4'd0;
    logic       dr0, bv0, ov0, er0;
    logic [6:0] bo0;

    logic       dv1 = 1'b0, dl1 = 1'b0, br1 = 1'b0;
    logic [3:0] din1 = 4'd0;
    logic       dr1, bv1, ov1, er1;
    logic [6:0] bo1;

`ifdef BCD2BIN_ECHO_SEG_EN
    logic [6:0] seg0, seg1;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    bcd_to_bin_accum #(.NUM_DIGITS(2), .BIN_W(7)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .digit_valid(dv0), .digit_in(din0), .digit_last(dl0), .digit_ready(dr0),
        .bin_valid(bv0), .bin_ready(br0), .bin_out(bo0),
        .overflow(ov0), .digit_err(er0)
`ifdef BCD2BIN_ECHO_SEG_EN
        , .echo_seg(seg0)
`endif
    );

    bcd_to_bin_accum #(.NUM_DIGITS(3), .BIN_W(7)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .digit_valid(dv1), .digit_in(din1), .digit_last(dl1), .digit_ready(dr1),
        .bin_valid(bv1), .bin_ready(br1), .bin_out(bo1),
        .overflow(ov1), .digit_err(er1)
`ifdef BCD2BIN_ECHO_SEG_EN
        , .echo_seg(seg1)
`endif
    );

    // Scoreboard consumers: compare each handed-off result against the queued expectation.
    always @(negedge clk) begin
        if (rst_n && bv0 && br0) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL dut0_unexpected_result got=%0d/%0b/%0b expected=none", bo0, ov0, er0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if ({bo0, ov0, er0} !== e) begin
                    failures++;
                    $display("FAIL dut0_result got bin=%0d ovf=%0b err=%0b expected bin=%0d ovf=%0b err=%0b",
                             bo0, ov0, er0, e.bin, e.ovf, e.err);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bv1 && br1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL dut1_unexpected_result got=%0d/%0b/%0b expected=none", bo1, ov1, er1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if ({bo1, ov1, er1} !== e) begin
                    failures++;
                    $display("FAIL dut1_result got bin=%0d ovf=%0b err=%0b expected bin=%0d ovf=%0b err=%0b",
                             bo1, ov1, er1, e.bin, e.ovf, e.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int k, input logic v, input logic [3:0] d, input logic l);
        if (k == 0) begin dv0 = v; din0 = d; dl0 = l; end
        else        begin dv1 = v; din1 = d; dl1 = l; end
    endtask

    // Presents one digit and returns just after the edge that accepted it.
    task automatic send_digit(input int k, input logic [3:0] d, input logic l);
        bit got = 0;
        int n = 0;
        drive(k, 1'b1, d, l);
        while (!got && n < 20) begin
            @(negedge clk);
            if ((k == 0) ? dr0 : dr1) got = 1;
            @(posedge clk);
            #1;
            n++;
        end
        drive(k, 1'b0, 4'd0, 1'b0);
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL send_digit_timeout dut=%0d digit=%0d got=not_accepted expected=accepted", k, d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({dr0, bv0, bo0, ov0, er0} !== {1'b1, 1'b0, 7'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got rdy=%0b vld=%0b bin=%0d ovf=%0b err=%0b expected 1 0 0 0 0",
                     dr0, bv0, bo0, ov0, er0);
        end
        checks++;
        if ({dr1, bv1} !== 2'b10) begin
            failures++;
            $display("FAIL reset_state_dut1 got rdy=%0b vld=%0b expected rdy=1 vld=0", dr1, bv1);
        end
`ifdef BCD2BIN_ECHO_SEG_EN
        checks++;
        if (seg0 !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_echo got=%b expected=1000000", seg0);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        br0 = 1'b1;
        q0.push_back('{bin: 7'd42, ovf: 1'b0, err: 1'b0});
        send_digit(0, 4'd4, 1'b0);
        checks++;
        if (bv0 !== 1'b0) begin
            failures++;
            $display("FAIL basic_no_early_valid got=%0b expected=0", bv0);
        end
        send_digit(0, 4'd2, 1'b0);
        checks++;
        if (bv0 !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency got bin_valid=%0b expected=1", bv0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_digit();
        br0 = 1'b1;
        q0.push_back('{bin: 7'd7, ovf: 1'b0, err: 1'b0});
        send_digit(0, 4'd7, 1'b1);
        @(negedge clk);
        checks++;
        if (dr0 !== 1'b0) begin
            failures++;
            $display("FAIL single_ready_low got=%0b expected=0", dr0);
        end
        @(negedge clk);
        checks++;
        if (dr0 !== 1'b1) begin
            failures++;
            $display("FAIL single_ready_back got=%0b expected=1", dr0);
        end
        @(posedge clk);
        #1;
        q0.push_back('{bin: 7'd99, ovf: 1'b0, err: 1'b0});
        send_digit(0, 4'd9, 1'b0);
        send_digit(0, 4'd9, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturate();
        br1 = 1'b1;
        q1.push_back('{bin: 7'd127, ovf: 1'b1, err: 1'b0});
        send_digit(1, 4'd1, 1'b0);
        send_digit(1, 4'd2, 1'b0);
        send_digit(1, 4'd8, 1'b0);
        checks++;
        if (ov1 !== 1'b1 || bo1 !== 7'd127) begin
            failures++;
            $display("FAIL saturate_out got bin=%0d ovf=%0b expected bin=127 ovf=1", bo1, ov1);
        end
        @(posedge clk);
        #1;
        q1.push_back('{bin: 7'd5, ovf: 1'b0, err: 1'b0});
        send_digit(1, 4'd0, 1'b0);
        send_digit(1, 4'd0, 1'b0);
        send_digit(1, 4'd5, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_digit_err();
        br0 = 1'b1;
        q0.push_back('{bin: 7'd3, ovf: 1'b0, err: 1'b1});
        send_digit(0, 4'hA, 1'b0);
`ifdef BCD2BIN_ECHO_SEG_EN
        checks++;
        if (seg0 !== 7'b0111111) begin
            failures++;
            $display("FAIL echo_dash got=%b expected=0111111", seg0);
        end
`endif
        send_digit(0, 4'd3, 1'b0);
`ifdef BCD2BIN_ECHO_SEG_EN
        checks++;
        if (seg0 !== 7'b0110000) begin
            failures++;
            $display("FAIL echo_three got=%b expected=0110000", seg0);
        end
`endif
        @(posedge clk);
        #1;
        q0.push_back('{bin: 7'd80, ovf: 1'b0, err: 1'b0});
        send_digit(0, 4'd8, 1'b0);
        send_digit(0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        br0 = 1'b0;
        q0.push_back('{bin: 7'd15, ovf: 1'b0, err: 1'b0});
        send_digit(0, 4'd1, 1'b0);
        send_digit(0, 4'd5, 1'b0);
        drive(0, 1'b1, 4'd6, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bv0, dr0, bo0} !== {1'b1, 1'b0, 7'd15}) begin
                failures++;
                $display("FAIL backpressure_hold cycle=%0d got vld=%0b rdy=%0b bin=%0d expected vld=1 rdy=0 bin=15",
                         i, bv0, dr0, bo0);
            end
            @(posedge clk);
            #1;
        end
        br0 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({dr0, bv0} !== 2'b10) begin
            failures++;
            $display("FAIL backpressure_release got rdy=%0b vld=%0b expected rdy=1 vld=0", dr0, bv0);
        end
        @(posedge clk);
        #1;
        drive(0, 1'b0, 4'd0, 1'b0);
        q0.push_back('{bin: 7'd61, ovf: 1'b0, err: 1'b0});
        send_digit(0, 4'd1, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midnumber();
        br0 = 1'b1;
        send_digit(0, 4'd5, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bv0, ov0, er0, dr0} !== 4'b0001) begin
            failures++;
            $display("FAIL midreset_state got vld=%0b ovf=%0b err=%0b rdy=%0b expected 0 0 0 1",
                     bv0, ov0, er0, dr0);
        end
        @(posedge clk);
        #1;
        q0.push_back('{bin: 7'd12, ovf: 1'b0, err: 1'b0});
        send_digit(0, 4'd1, 1'b0);
        send_digit(0, 4'd2, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_digit();
        test_saturate();
        test_digit_err();
        test_backpressure();
        test_reset_midnumber();
        repeat (3) @(posedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got pending=%0d/%0d expected=0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_accum.md
Name: bcd_to_bin_accum

Overview:
Reverse path of the team's binary-to-BCD display converter. It accepts decimal (BCD) digits one per handshake, most-significant digit first, and accumulates them into a binary value using acc = acc*10 + digit. It flags invalid digits and overflow, then presents the result on a valid/ready output. It sits between keypad/digit-entry logic and the arithmetic datapath.

Parameters:
NUM_DIGITS, 2, maximum digits per number; the number closes automatically on the NUM_DIGITS-th digit (range 1..8).
BIN_W, 7, width of the binary result; the value saturates at 2^BIN_W-1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
digit_valid  input  1  digit_in/digit_last valid this cycle
digit_in  input  4  BCD digit, MSD first
digit_last  input  1  this digit ends the number
digit_ready  output  1  block can accept a digit
bin_valid  output  1  result available
bin_ready  input  1  consumer accepts result
bin_out  output  BIN_W  binary result
overflow  output  1  result saturated; qualified by bin_valid
digit_err  output  1  at least one digit >9 in this number; qualified by bin_valid

Behaviour:
- Reset: rst_n sampled low at a clk edge. Takes effect that edge and overrides any handshake in flight. Afterwards: state=ACCUM, acc=0, count=0, bin_valid=0, bin_out=0, overflow=0, digit_err=0, digit_ready=1. Any partial number is discarded.
- States:
  - ACCUM: digit_ready=1, bin_valid=0.
  - OUT: digit_ready=0, bin_valid=1.
- Digit accept: happens when digit_valid && digit_ready.
  - digit_in > 9: digit_err is set (sticky for this number) and the digit is treated as 0.
  - Arithmetic: next = acc*10 + d, computed at BIN_W+4 bits.
  - If next > 2^BIN_W-1: acc = 2^BIN_W-1 and overflow is set (sticky). Later digits keep acc saturated.
  - count increments on each accepted digit.
- Closing a number: digit_last=1, or count reaching NUM_DIGITS on this accept.
  - Next state is OUT. bin_out is loaded with the final acc.
  - bin_valid rises in the cycle after the closing digit is accepted (latency 1).
- OUT:
  - bin_out, overflow and digit_err are held stable while bin_ready=0.
  - On bin_valid && bin_ready: next state ACCUM; acc, count and the sticky flags clear.
  - digit_ready returns to 1 in the following cycle. There is no bypass, so throughput is at most one number per (digits + 1) cycles.
  - bin_out keeps its last value until the next load.
- Ignored inputs:
  - digit_valid while digit_ready=0 is ignored. The producer must hold the digit until it is accepted.
  - digit_last with digit_valid=0 is ignored.
- Zero-digit number: not possible; a number always contains at least one digit.

Optional Feature:
Macro BCD2BIN_ECHO_SEG_EN.
- Defined: adds output port echo_seg [6:0]. It holds the seven-segment pattern (active-low, bit0=a … bit6=g) of the last accepted digit, registered on accept.
  - Reset value 7'b1000000 (shows "0").
  - A digit >9 shows 7'b0111111 (dash, segment g only).
  - The value is not cleared on result handoff.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- After reset, digits 4, 2 (second with digit_last=0, closing at NUM_DIGITS=2) and bin_ready=1 -> bin_valid one cycle after the second accept, bin_out=42 (7'b0101010), overflow=0, digit_err=0.
- Single digit 7 with digit_last=1 -> bin_out=7; digit_ready=0 for exactly one cycle; the next number (9, 9) -> 99.
- NUM_DIGITS=3, BIN_W=7, digits 1, 2, 8 -> 128 saturates: bin_out=127, overflow=1; the next number 0, 0, 5 gives 5 with overflow=0.
- Digits 0xA, 3 -> digit_err=1, bin_out=3; with BCD2BIN_ECHO_SEG_EN, echo_seg=7'b0111111 after the first digit and 7'b0110000 after the second.
- Result ready, bin_ready held 0 for 5 cycles while digit_valid=1 with digit 6 -> bin_out stable, digit_ready=0, the digit is not accepted; after bin_ready=1 the digit 6 is accepted next cycle.
- Digit 5 accepted, then rst_n=0 for one cycle, then digits 1, 2 -> bin_out=12 (the 5 is discarded); flags and bin_valid are 0 immediately after reset.
